water_level_ctrl: RTL and testbench

WATER_LEVEL_CTRL -- requirements
Module: water_level_ctrl

---
 rtl/water_level_ctrl_pkg.sv | 13 +
 rtl/water_level_ctrl_if.sv | 10 +
 rtl/water_level_ctrl.sv | 88 ++++++++
 tb/tb_water_level_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/water_level_ctrl_pkg.sv
// water_level_ctrl_pkg: shared washer constants and the water-level FSM state encoding.
package water_level_ctrl_pkg;
  localparam int HYST_DEF = 4;
  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int MAX_TIME_DEF = 1023;
  localparam int MAX_RETRY_DEF = 3;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;
endpackage

// File: rtl/water_level_ctrl_if.sv
// water_level_ctrl_if: job request, sensor inputs and actuator/status outputs of the water-level controller.
interface water_level_ctrl_if;
  logic start, op, flow_error, abort, clr_fault;
  logic [9:0] target_level, water_level_sensor;
  logic inlet_valve, drain_pump, mode, mon_rst, busy, done, fault;
  modport master(output start, op, target_level, water_level_sensor, flow_error, abort, clr_fault,
                 input inlet_valve, drain_pump, mode, mon_rst, busy, done, fault);
  modport slave(input start, op, target_level, water_level_sensor, flow_error, abort, clr_fault,
                output inlet_valve, drain_pump, mode, mon_rst, busy, done, fault);
endinterface

// File: rtl/water_level_ctrl.sv
// water_level_ctrl: fill/drain job FSM with settle recheck, retry limit, phase timeout and sticky fault.
module water_level_ctrl
  import water_level_ctrl_pkg::*;
#(
  parameter int HYST = HYST_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int MAX_TIME = MAX_TIME_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input logic clk,
  input logic reset,
  water_level_ctrl_if.slave bus
);
  localparam int TW = $clog2(MAX_TIME + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [2:0] r_state, w_next;
  logic [9:0] r_target;
  logic r_op;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_settle;
  logic [RW-1:0] r_retry;
  logic r_inlet, r_pump, r_mon_rst, r_busy, r_done, r_fault;
  logic [10:0] w_sens, w_tgt, w_new_tgt;
  logic w_start_met, w_err, w_settle_end, w_recheck, w_phase;
  // 11-bit compares so that adding HYST to a level near 1023 cannot wrap
  assign w_sens = {1'b0, bus.water_level_sensor};
  assign w_tgt = {1'b0, r_target};
  assign w_new_tgt = {1'b0, bus.target_level};
  assign w_start_met = bus.op ? w_sens >= w_new_tgt : w_sens <= w_new_tgt;
  assign w_err = bus.flow_error || r_timer == TW'(MAX_TIME - 1);
  assign w_settle_end = r_settle == SW'(SETTLE_CYCLES - 1);
  assign w_recheck = r_op ? w_sens + 11'(HYST) < w_tgt : w_sens > w_tgt + 11'(HYST);
  assign w_phase = w_next == S_FILL || w_next == S_DRAIN;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = !bus.start ? S_IDLE : w_start_met ? S_SETTLE : bus.op ? S_FILL : S_DRAIN;
      S_FILL:   w_next = bus.abort ? S_IDLE : w_err ? S_FAULT : w_sens >= w_tgt ? S_SETTLE : S_FILL;
      S_DRAIN:  w_next = bus.abort ? S_IDLE : w_err ? S_FAULT : w_sens <= w_tgt ? S_SETTLE : S_DRAIN;
      S_SETTLE: w_next = bus.abort ? S_IDLE : !w_settle_end ? S_SETTLE : !w_recheck ? S_DONE :
                         r_retry == RW'(MAX_RETRY) ? S_FAULT : r_op ? S_FILL : S_DRAIN;
      S_DONE:   w_next = S_IDLE;
      S_FAULT:  w_next = bus.clr_fault ? S_IDLE : S_FAULT;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_target <= '0;
      r_op <= 1'b0;
      r_timer <= '0;
      r_settle <= '0;
      r_retry <= '0;
      r_inlet <= 1'b0;
      r_pump <= 1'b0;
      r_mon_rst <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.start) begin
        r_op <= bus.op;
        r_target <= bus.target_level;
        r_retry <= '0;
      end else if (r_state == S_SETTLE && w_phase) begin
        r_retry <= r_retry + RW'(1);
      end
      r_timer <= (w_phase && w_next == r_state) ? r_timer + TW'(1) : '0;
      r_settle <= (r_state == S_SETTLE && w_next == S_SETTLE) ? r_settle + SW'(1) : '0;
      r_inlet <= w_next == S_FILL;
      r_pump <= w_next == S_DRAIN;
      r_mon_rst <= !w_phase;
      r_busy <= w_next != S_IDLE && w_next != S_FAULT;
      r_done <= w_next == S_DONE;
      r_fault <= w_next == S_FAULT;
    end
  end
  assign bus.inlet_valve = r_inlet;
  assign bus.drain_pump = r_pump;
  assign bus.mode = r_op;
  assign bus.mon_rst = r_mon_rst;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.fault = r_fault;
endmodule

// File: tb/tb_water_level_ctrl.sv
// tb_water_level_ctrl: directed scenarios plus random jobs checked every cycle against a phase-level reference model.
module tb_water_level_ctrl;
  localparam int HYST = 4;
  localparam int SETTLE_CYCLES = 8;
  localparam int MAX_TIME = 1023;
  localparam int MAX_RETRY = 3;
  typedef enum {P_IDLE, P_FILL, P_DRAIN, P_SETTLE, P_DONE, P_FAULT} ph_t;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0, n_bad = 0;
  int n_inlet, n_pump, n_done, n_settle, n_rise;
  logic prev_inlet = 1'b0;
  ph_t m_ph;
  logic m_op;
  int m_tgt, m_time, m_left, m_retry;
  water_level_ctrl_if bus ();
  water_level_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] outs();
    return {bus.inlet_valve, bus.drain_pump, bus.mode, bus.mon_rst, bus.busy, bus.done, bus.fault};
  endfunction
  function automatic logic [6:0] exp_outs();
    logic act = m_ph == P_FILL || m_ph == P_DRAIN;
    return {m_ph == P_FILL, m_ph == P_DRAIN, m_op, !act, m_ph != P_IDLE && m_ph != P_FAULT,
            m_ph == P_DONE, m_ph == P_FAULT};
  endfunction
  task automatic m_reset();
    m_ph = P_IDLE;
    m_op = 1'b0;
    m_tgt = 0;
    m_time = 0;
    m_left = 0;
    m_retry = 0;
  endtask
  task automatic settle_in();
    m_ph = P_SETTLE;
    m_left = SETTLE_CYCLES;
  endtask
  task automatic model_step();
    int s = int'(bus.water_level_sensor);
    int t = int'(bus.target_level);
    case (m_ph)
      P_IDLE: if (bus.start) begin
        m_op = bus.op;
        m_tgt = t;
        m_retry = 0;
        m_time = 0;
        if (bus.op ? s >= t : s <= t) settle_in();
        else m_ph = bus.op ? P_FILL : P_DRAIN;
      end
      P_FILL, P_DRAIN: begin
        m_time++;
        if (bus.abort) m_ph = P_IDLE;
        else if (bus.flow_error || m_time == MAX_TIME) m_ph = P_FAULT;
        else if (m_ph == P_FILL ? s >= m_tgt : s <= m_tgt) settle_in();
      end
      P_SETTLE: begin
        m_left--;
        if (bus.abort) m_ph = P_IDLE;
        else if (m_left == 0) begin
          if (!(m_op ? s + HYST < m_tgt : s > m_tgt + HYST)) m_ph = P_DONE;
          else if (m_retry == MAX_RETRY) m_ph = P_FAULT;
          else begin
            m_retry++;
            m_time = 0;
            m_ph = m_op ? P_FILL : P_DRAIN;
          end
        end
      end
      P_DONE: m_ph = P_IDLE;
      default: if (bus.clr_fault) m_ph = P_IDLE;
    endcase
  endtask
  task automatic step(string tag);
    model_step();
    @(posedge clk);
    #1;
    chk(tag, 32'(outs()), 32'(exp_outs()));
    n_inlet += int'(bus.inlet_valve);
    n_pump += int'(bus.drain_pump);
    n_done += int'(bus.done);
    n_settle += int'(bus.busy && !bus.inlet_valve && !bus.drain_pump && !bus.done);
    n_rise += int'(bus.inlet_valve && !prev_inlet);
    prev_inlet = bus.inlet_valve;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.flow_error = 1'b0;
    bus.clr_fault = 1'b0;
  endtask
  task automatic clr_cnt();
    n_inlet = 0;
    n_pump = 0;
    n_done = 0;
    n_settle = 0;
    n_rise = 0;
  endtask
  task automatic job(logic op, int tgt, int sens);
    bus.op = op;
    bus.target_level = 10'(tgt);
    bus.water_level_sensor = 10'(sens);
    bus.start = 1'b1;
    step("job_start");
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.target_level = '0;
    bus.water_level_sensor = '0;
    bus.flow_error = 1'b0;
    bus.abort = 1'b0;
    bus.clr_fault = 1'b0;
    m_reset();
    clr_cnt();
    #12;
    chk("reset_outs", 32'(outs()), 32'h08);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr_cnt();
    job(1'b1, 200, 0);
    for (int k = 1; k <= 25; k++) begin
      bus.water_level_sensor = 10'(k * 20 > 200 ? 200 : k * 20);
      step("fill");
    end
    chk("fill_inlet_cycles", n_inlet, 200 / 20);
    chk("fill_settle_cycles", n_settle, SETTLE_CYCLES);
    chk("fill_done_pulses", n_done, 1);
    clr_cnt();
    job(1'b1, 200, 190);
    for (int k = 0; k < 200 && m_ph != P_FAULT; k++) begin
      bus.water_level_sensor = m_ph == P_FILL ? 10'd200 : 10'd190;
      step("refill");
    end
    chk("refill_entries", n_rise, MAX_RETRY + 1);
    chk("refill_fault", 32'(bus.fault), 1);
    bus.start = 1'b1;
    step("fault_ignores_start");
    bus.clr_fault = 1'b1;
    step("clr_fault");
    clr_cnt();
    job(1'b0, 50, 300);
    for (int k = 0; k < 1100 && bus.drain_pump; k++) step("timeout");
    chk("timeout_pump_cycles", n_pump, MAX_TIME);
    chk("timeout_fault", 32'(bus.fault), 1);
    bus.clr_fault = 1'b1;
    step("clr_fault");
    job(1'b0, 50, 300);
    for (int k = 0; k < 3; k++) step("stall_run");
    bus.flow_error = 1'b1;
    step("stall");
    chk("stall_fault_pump", 32'({bus.fault, bus.drain_pump}), 32'b10);
    bus.clr_fault = 1'b1;
    step("clr_fault");
    clr_cnt();
    job(1'b1, 200, 100);
    for (int k = 0; k < 2; k++) step("abort_run");
    bus.water_level_sensor = 10'd200;
    bus.abort = 1'b1;
    step("abort");
    chk("abort_idle", 32'({bus.busy, bus.inlet_valve}), 0);
    for (int k = 0; k < 12; k++) step("abort_after");
    chk("abort_no_done", n_done, 0);
    clr_cnt();
    job(1'b1, 1023, 1023);
    bus.water_level_sensor = 10'd1020;
    for (int k = 0; k < 12; k++) step("wrap_fill");
    chk("wrap_fill_done", n_done, 1);
    chk("wrap_fill_no_refill", n_rise, 0);
    clr_cnt();
    job(1'b0, 1020, 1000);
    bus.water_level_sensor = 10'd1023;
    for (int k = 0; k < 12; k++) step("wrap_drain");
    chk("wrap_drain_done", n_done, 1);
    chk("wrap_drain_no_redrain", n_pump, 0);
    job(1'b1, 500, 100);
    for (int k = 0; k < 3; k++) step("rst_fill");
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'h08);
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    prev_inlet = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int s;
      bus.start = $urandom_range(0, 3) == 0;
      bus.op = 1'($urandom_range(0, 1));
      bus.target_level = 10'($urandom_range(0, 1023));
      bus.abort = $urandom_range(0, 39) == 0;
      bus.flow_error = $urandom_range(0, 59) == 0;
      bus.clr_fault = $urandom_range(0, 7) == 0;
      s = int'(bus.water_level_sensor);
      if (m_ph == P_FILL) s += int'($urandom_range(0, 40));
      else if (m_ph == P_DRAIN) s -= int'($urandom_range(0, 40));
      else s += int'($urandom_range(0, 10)) - 5;
      if ($urandom_range(0, 99) == 0) s = int'($urandom_range(0, 1023));
      s = s < 0 ? 0 : s > 1023 ? 1023 : s;
      bus.water_level_sensor = 10'(s);
      step("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
